// File: rtl/siso_layer_scheduler.sv
// siso_layer_scheduler: read scheduler for a layered SISO LDPC row unit.
// Issues ADDRDEPTH row reads per layer, inserts an inter-layer gap, drains the
// write-back pipeline after the final layer and pulses done.
// Optional feature macro: SISO_SCHED_OVERLAP_EN (shortest safe inter-layer gap
// instead of a full WRLAT drain between layers).
module siso_layer_scheduler #(
  parameter int ADDRWIDTH = 5,
  parameter int ADDRDEPTH = 20,
  parameter int LAYERS    = 2,
  parameter int WRLAT     = 14,
  parameter int ITERBITS  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ITERBITS-1:0]  max_iter,
  input  logic                 halt,
  output logic                 rdlayer,
  output logic [ADDRWIDTH-1:0] rdaddress,
  output logic                 rden_LLR,
  output logic                 rden_E,
  output logic [ITERBITS-1:0]  iter_count,
  output logic                 busy,
  output logic                 done
);

`ifdef SISO_SCHED_OVERLAP_EN
  localparam int GAP_LEN = (WRLAT - ADDRDEPTH + 1 > 0) ? (WRLAT - ADDRDEPTH + 1) : 0;
`else
  localparam int GAP_LEN = WRLAT;
`endif

  localparam int CW = (WRLAT < 1) ? 1 : $clog2(WRLAT + 1);
  localparam logic [CW-1:0]        GAP_INIT   = (GAP_LEN > 0) ? CW'(GAP_LEN - 1) : '0;
  localparam logic [CW-1:0]        DRAIN_INIT = CW'(WRLAT - 1);
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR  = ADDRWIDTH'(ADDRDEPTH - 1);
  localparam logic                 LAST_LAYER = 1'(LAYERS - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_GAP, S_DRAIN, S_DONE} state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [ITERBITS-1:0]  last_iter, last_iter_n;
  logic                 halt_seen, halt_seen_n;
  logic                 layer_n, llr_n, e_n, busy_n, done_n;
  logic [ADDRWIDTH-1:0] addr_n;
  logic [ITERBITS-1:0]  iter_n;
  logic                 advance;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_iter  <= '0;
      halt_seen  <= 1'b0;
      rdlayer    <= 1'b0;
      rdaddress  <= '0;
      rden_LLR   <= 1'b0;
      rden_E     <= 1'b0;
      iter_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      last_iter  <= last_iter_n;
      halt_seen  <= halt_seen_n;
      rdlayer    <= layer_n;
      rdaddress  <= addr_n;
      rden_LLR   <= llr_n;
      rden_E     <= e_n;
      iter_count <= iter_n;
      busy       <= busy_n;
      done       <= done_n;
    end
  end

  // Next-state and next-output decode; layer advance is shared by RUN (zero
  // gap) and GAP expiry, so it is applied once after the case.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_iter_n = last_iter;
    halt_seen_n = halt_seen;
    layer_n     = rdlayer;
    addr_n      = rdaddress;
    iter_n      = iter_count;
    llr_n       = 1'b0;
    e_n         = 1'b0;
    busy_n      = 1'b0;
    done_n      = 1'b0;
    advance     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n     = S_RUN;
          last_iter_n = (max_iter == '0) ? '0 : max_iter - ITERBITS'(1);
          halt_seen_n = 1'b0;
          layer_n     = 1'b0;
          addr_n      = '0;
          iter_n      = '0;
          cnt_n       = '0;
          llr_n       = 1'b1;
          busy_n      = 1'b1;
        end
      end
      S_RUN: begin
        busy_n = 1'b1;
        if (halt) halt_seen_n = 1'b1;
        if (rdaddress != LAST_ADDR) begin
          addr_n = rdaddress + ADDRWIDTH'(1);
          llr_n  = 1'b1;
          e_n    = (iter_count != '0);
        end else if (halt || halt_seen ||
                     ((rdlayer == LAST_LAYER) && (iter_count == last_iter))) begin
          state_n = S_DRAIN;
          cnt_n   = DRAIN_INIT;
        end else if (GAP_LEN == 0) begin
          advance = 1'b1;
        end else begin
          state_n = S_GAP;
          cnt_n   = GAP_INIT;
        end
      end
      S_GAP: begin
        busy_n = 1'b1;
        if (halt) halt_seen_n = 1'b1;
        if (cnt == '0) advance = 1'b1;
        else           cnt_n   = cnt - CW'(1);
      end
      S_DRAIN: begin
        if (cnt == '0) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else begin
          cnt_n  = cnt - CW'(1);
          busy_n = 1'b1;
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    if (advance) begin
      state_n = S_RUN;
      addr_n  = '0;
      if (rdlayer == LAST_LAYER) begin
        layer_n = 1'b0;
        iter_n  = iter_count + ITERBITS'(1);
      end else begin
        layer_n = 1'b1;
      end
      llr_n  = 1'b1;
      e_n    = (iter_n != '0);
      busy_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_siso_layer_scheduler.sv
// Testbench for siso_layer_scheduler: cycle-accurate trace comparison against
// a schedule model built from layer/gap/drain durations.
module tb_siso_layer_scheduler;

  localparam int ADDRDEPTH = 20;
  localparam int LAYERS    = 2;
  localparam int WRLAT     = 14;
`ifdef SISO_SCHED_OVERLAP_EN
  localparam int G = (WRLAT - ADDRDEPTH + 1 > 0) ? (WRLAT - ADDRDEPTH + 1) : 0;
`else
  localparam int G = WRLAT;
`endif

  logic       clk = 1'b0;
  logic       rst, start, halt;
  logic [4:0] max_iter;
  logic       rdlayer, rden_LLR, rden_E, busy, done;
  logic [4:0] rdaddress, iter_count;

  int checks   = 0;
  int failures = 0;
  logic [14:0] exp_vec [0:511];

  siso_layer_scheduler #(.ADDRWIDTH(5), .ADDRDEPTH(ADDRDEPTH), .LAYERS(LAYERS),
                         .WRLAT(WRLAT), .ITERBITS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .max_iter(max_iter), .halt(halt),
    .rdlayer(rdlayer), .rdaddress(rdaddress), .rden_LLR(rden_LLR),
    .rden_E(rden_E), .iter_count(iter_count), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pack(input int ly, input int a, input bit llr,
                                       input bit e, input int it, input bit b,
                                       input bit d);
    return {1'(ly), 5'(a), llr, e, 5'(it), b, d};
  endfunction

  function automatic logic [14:0] obs();
    return {rdlayer, rdaddress, rden_LLR, rden_E, iter_count, busy, done};
  endfunction

  // Schedule model: reads per layer, G-cycle gaps, WRLAT drain, one done cycle.
  task automatic build(input int mi, input int hc, output int end_cyc);
    int eff = (mi == 0) ? 1 : mi;
    int t = 1;
    int win = 1;
    bit fin = 0;
    end_cyc = 0;
    for (int it = 0; it < eff && !fin; it++) begin
      for (int ly = 0; ly < LAYERS && !fin; ly++) begin
        for (int a = 0; a < ADDRDEPTH; a++) begin
          exp_vec[t] = pack(ly, a, 1'b1, it >= 1, it, 1'b1, 1'b0);
          t++;
        end
        if ((it == eff - 1 && ly == LAYERS - 1) || (hc >= win && hc <= t - 1)) begin
          repeat (WRLAT) begin
            exp_vec[t] = pack(ly, ADDRDEPTH - 1, 1'b0, 1'b0, it, 1'b1, 1'b0);
            t++;
          end
          exp_vec[t] = pack(ly, ADDRDEPTH - 1, 1'b0, 1'b0, it, 1'b0, 1'b1);
          t++;
          exp_vec[t] = pack(ly, ADDRDEPTH - 1, 1'b0, 1'b0, it, 1'b0, 1'b0);
          end_cyc = t;
          fin = 1;
        end else begin
          win = t;
          repeat (G) begin
            exp_vec[t] = pack(ly, ADDRDEPTH - 1, 1'b0, 1'b0, it, 1'b1, 1'b0);
            t++;
          end
        end
      end
    end
  endtask

  // Runs one decode from an aligned IDLE cycle; xs<0 picks a random ignored start.
  task automatic run_seq(input string name, input int mi, input int hc,
                         input int xs, output int done_obs);
    int end_cyc;
    build(mi, hc, end_cyc);
    if (xs < 0) xs = $urandom_range(1, end_cyc - 1);
    done_obs = -1;
    max_iter = 5'(mi);
    for (int cyc = 0; cyc <= end_cyc; cyc++) begin
      start = (cyc == 0) || (cyc == xs);
      halt  = (cyc == hc);
      @(negedge clk);
      if (cyc >= 1) begin
        checks++;
        if (obs() !== exp_vec[cyc]) begin
          failures++;
          $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, obs(), exp_vec[cyc]);
        end
        if (done === 1'b1 && done_obs < 0) done_obs = cyc;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    halt  = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (obs() !== 15'h0) begin
      failures++;
      $display("FAIL reset_state actual=%h required=%h", obs(), 15'h0);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (obs() !== 15'h0) begin
      failures++;
      $display("FAIL idle_after_reset actual=%h required=%h", obs(), 15'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_spec_vectors();
    int d;
    int exp1 = (G == 0) ? 55 : 69;
    int exp2 = (G == 0) ? 95 : 137;
    run_seq("iter1", 1, 0, 0, d);
    checks++;
    if (d !== exp1) begin
      failures++;
      $display("FAIL done_iter1 actual=%0d required=%0d", d, exp1);
    end
    run_seq("iter2", 2, 0, 0, d);
    checks++;
    if (d !== exp2) begin
      failures++;
      $display("FAIL done_iter2 actual=%0d required=%0d", d, exp2);
    end
    run_seq("halt5", 3, 5, 0, d);
    checks++;
    if (d !== 35) begin
      failures++;
      $display("FAIL done_halt actual=%0d required=%0d", d, 35);
    end
    run_seq("iter0_restart", 0, 0, 30, d);
    checks++;
    if (d !== exp1) begin
      failures++;
      $display("FAIL done_iter0 actual=%0d required=%0d", d, exp1);
    end
  endtask

  task automatic test_random();
    int d;
    for (int n = 0; n < 10; n++) begin
      int mi = $urandom_range(0, 3);
      int hc = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 150) : 0;
      run_seq("random", mi, hc, -1, d);
    end
  endtask

  task automatic test_reset_midrun();
    max_iter = 5'd1;
    start    = 1'b1;
    for (int cyc = 0; cyc <= 12; cyc++) begin
      rst = (cyc == 10);
      @(negedge clk);
      if (cyc == 5) begin
        checks++;
        if (obs() !== pack(0, 4, 1'b1, 1'b0, 0, 1'b1, 1'b0)) begin
          failures++;
          $display("FAIL pre_reset_run actual=%h required=%h", obs(),
                   pack(0, 4, 1'b1, 1'b0, 0, 1'b1, 1'b0));
        end
      end
      if (cyc == 11) begin
        checks++;
        if (obs() !== 15'h0) begin
          failures++;
          $display("FAIL midrun_reset actual=%h required=%h", obs(), 15'h0);
        end
      end
      if (cyc == 12) begin
        checks++;
        if (obs() !== pack(0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0)) begin
          failures++;
          $display("FAIL restart_after_reset actual=%h required=%h", obs(),
                   pack(0, 0, 1'b1, 1'b0, 0, 1'b1, 1'b0));
        end
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    rst   = 1'b1;
    @(posedge clk); #1;
    rst   = 1'b0;
    @(negedge clk);
    checks++;
    if (obs() !== 15'h0) begin
      failures++;
      $display("FAIL final_reset actual=%h required=%h", obs(), 15'h0);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    halt     = 1'b0;
    max_iter = '0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_spec_vectors();
    test_random();
    test_reset_midrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
